// File: rtl/instr_prefetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_buffer_pkg
// Description : Shared types and constants for the instruction prefetch
//               buffer and its queue.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_prefetch_buffer_pkg;

    localparam int                  c_xlen             = 32;
    // One queue entry is {PC+4, INSTR}
    localparam int                  c_entry_w          = 2 * c_xlen;
    localparam logic [c_xlen-1:0]   c_word_inc         = 32'd4;
    localparam logic [c_xlen-1:0]   c_default_reset_pc = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_prefetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_buffer_if
// Description : Bundles the redirect, instruction-memory and consumer
//               handshakes of the prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_prefetch_buffer_if;
    import instr_prefetch_buffer_pkg::*;

    logic              REDIRECT;
    logic [c_xlen-1:0] REDIRECT_PC;
    logic              IMEM_REQ;
    logic [c_xlen-1:0] IMEM_ADDR;
    logic              IMEM_ACK;
    logic [c_xlen-1:0] IMEM_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [c_xlen-1:0] PC_4_OUT;
    logic [c_xlen-1:0] INSTR;

    // Prefetch buffer side
    modport master (
        input  REDIRECT, REDIRECT_PC, IMEM_ACK, IMEM_DATA, OUT_READY,
        output IMEM_REQ, IMEM_ADDR, OUT_VALID, PC_4_OUT, INSTR
    );

    // Environment side: memory, consumer and redirect source
    modport slave (
        output REDIRECT, REDIRECT_PC, IMEM_ACK, IMEM_DATA, OUT_READY,
        input  IMEM_REQ, IMEM_ADDR, OUT_VALID, PC_4_OUT, INSTR
    );

endinterface
`default_nettype wire

// File: rtl/instr_prefetch_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Synchronous DEPTH x WIDTH FIFO with push, pop, clear and an
//               occupancy count. Clear overrides push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = c_entry_w
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_clear,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int                 PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]     c_full    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]     c_cnt_one = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]   c_ptr_one = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pops on an empty queue and pushes on a full one are ignored
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents beyond the count are never observed
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_buffer
// Description : Fetch-side prefetch stage. Issues sequential word fetches to
//               instruction memory, queues {PC+4, INSTR} pairs and hands them
//               to the IF/ID stage; a redirect discards all pending work.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [c_xlen-1:0] RESET_PC = c_default_reset_pc
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    instr_prefetch_buffer_if.master     bus
);

    localparam int               CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [c_xlen-1:0]  r_fetch_pc;
    logic [c_xlen-1:0]  r_drop_addr;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_post_cnt;
    logic [c_entry_w-1:0] w_head;
    logic               w_ack_req;
    logic               w_push;
    logic               w_pop;

    // A redirect suppresses both the consumer pop and the returning word
    assign w_pop      = bus.OUT_VALID && bus.OUT_READY && !bus.REDIRECT;
    assign w_ack_req  = (r_state == ST_REQ) && bus.IMEM_ACK;
    assign w_push     = w_ack_req && !bus.REDIRECT;
    // Occupancy after this cycle's push; only meaningful while in ST_REQ
    assign w_post_cnt = w_count + CNT_W'(1) - CNT_W'(w_pop);

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory-request outputs
    always_comb begin
        w_state_nxt   = r_state;
        bus.IMEM_REQ  = 1'b0;
        bus.IMEM_ADDR = r_fetch_pc;
        case (r_state)
            ST_IDLE: begin
                if (!bus.REDIRECT && (w_count < c_depth_cnt)) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.IMEM_REQ = 1'b1;
                if (bus.REDIRECT) begin
                    // An unacknowledged request must still finish its handshake
                    w_state_nxt = bus.IMEM_ACK ? ST_IDLE : ST_DROP;
                end else if (bus.IMEM_ACK) begin
                    w_state_nxt = (w_post_cnt < c_depth_cnt) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                bus.IMEM_REQ  = 1'b1;
                bus.IMEM_ADDR = r_drop_addr;
                if (bus.IMEM_ACK) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch address tracking; the stale address is captured for ST_DROP
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            if (bus.REDIRECT) begin
                r_fetch_pc <= bus.REDIRECT_PC;
            end else if (w_ack_req) begin
                r_fetch_pc <= r_fetch_pc + c_word_inc;
            end
            if ((r_state == ST_REQ) && bus.REDIRECT && !bus.IMEM_ACK) begin
                r_drop_addr <= r_fetch_pc;
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_clear (bus.REDIRECT),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_fetch_pc + c_word_inc, bus.IMEM_DATA}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign bus.OUT_VALID = (w_count != '0);
    assign bus.PC_4_OUT  = w_head[c_entry_w-1:c_xlen];
    assign bus.INSTR     = w_head[c_xlen-1:0];

endmodule
`default_nettype wire

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Fetch-side prefetch stage between instruction memory and the IF_ID pipeline register.
- Issues sequential word fetches over a req/ack handshake to a variable-latency instruction memory.
- Buffers up to DEPTH {PC+4, INSTR} pairs and presents them to IF/IF_ID with a valid/ready handshake.
- Discards all buffered and in-flight work on a branch redirect from EX/Controller.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-low reset
REDIRECT  in  1  flush queue and restart fetch (taken branch resolved)
REDIRECT_PC  in  32  new fetch address, sampled when REDIRECT=1
IMEM_REQ  out  1  fetch request to instruction memory
IMEM_ADDR  out  32  fetch address; stable while IMEM_REQ=1 until ack
IMEM_ACK  in  1  memory returns IMEM_DATA this cycle (may coincide with REQ)
IMEM_DATA  in  32  fetched instruction word
OUT_VALID  out  1  head entry available
OUT_READY  in  1  consumer takes head this cycle (pop when VALID&READY)
PC_4_OUT  out  32  head entry PC+4
INSTR  out  32  head entry instruction

Behaviour:
- Reset (RST=0 at edge): FSM=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, IMEM_REQ=0, OUT_VALID=0. PC_4_OUT/INSTR are don't-care while OUT_VALID=0.
- FSM states:
  - IDLE: IMEM_REQ=0. Go to REQ when count<DEPTH and REDIRECT=0.
  - REQ: IMEM_REQ=1, IMEM_ADDR=fetch_pc. On IMEM_ACK:
    - push {fetch_pc+4, IMEM_DATA}; fetch_pc+=4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
    - Stay REQ if post-push/pop count<DEPTH, else IDLE.
  - DROP: IMEM_REQ=1 with stale address held. On IMEM_ACK, discard data and go IDLE.
- At most one outstanding request. Zero-wait memory (ACK in the same cycle as REQ) sustains 1 push per cycle.
- Pop: when OUT_VALID & OUT_READY, head advances. Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by construction: a request is issued only when count<DEPTH. Underflow is impossible: pop requires VALID.
- OUT_VALID = (count!=0). Head outputs come from registered storage; no combinational path from IMEM_DATA.
- Latency: reset released at edge 0 -> REQ during cycle 1 -> with ACK in cycle 1, OUT_VALID=1 in cycle 2.
- REDIRECT=1 has top priority:
  - Clears queue (count=0, pointers reset) and loads fetch_pc=REDIRECT_PC. OUT_VALID=0 next cycle.
  - Any pop in the same cycle has no effect.
  - In REQ without ACK that cycle -> DROP (handshake must complete).
  - In REQ with ACK that cycle -> data discarded, go IDLE.
  - In DROP or IDLE -> state unchanged, fetch_pc updated.
  - Repeated REDIRECT while in DROP: latest REDIRECT_PC wins.
- First post-redirect fetch issues on the cycle after IDLE is reached.
- RST=0 mid-handshake: state returns to IDLE and IMEM_REQ drops. The memory is reset by the same RST.

Decomposition:
- Shared package holds:
  - FSM encoding (IDLE=2'd0, REQ=2'd1, DROP=2'd2)
  - entry width constant (64 = PC+4 ‖ INSTR)
  - word increment constant (32'd4)
  - default RESET_PC
- Sub-module prefetch_fifo: synchronous DEPTH x 64 FIFO with push, pop, clear and count output. Clear has priority over push/pop. Reused later for a data-side store buffer.
- FSM and fetch_pc live in the top block.

Test Plan:
- Reset then zero-wait memory (ACK tied to REQ, IMEM_DATA=addr^32'hA5A5_0000), OUT_READY=1 -> OUT_VALID rises in cycle 2. Stream is PC_4_OUT=4,8,12… with matching INSTR, one per cycle.
- OUT_READY=0, zero-wait memory -> exactly 4 acks, then IMEM_REQ=0 and count=4. Raise OUT_READY for 1 cycle -> exactly one new request at IMEM_ADDR=16.
- 3-cycle memory latency, REDIRECT with REDIRECT_PC=32'h100 one cycle after REQ -> FSM enters DROP and IMEM_ADDR stays at the stale address. Stale data is discarded and the next request is at 32'h100. First output has PC_4_OUT=32'h104.
- REDIRECT coincident with IMEM_ACK and OUT_VALID&OUT_READY -> no push, no pop side effect. OUT_VALID=0 next cycle and the next IMEM_ADDR equals REDIRECT_PC.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory -> IMEM_ADDR sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. PC_4_OUT sequence FFFF_FFFC, 0000_0000, 0000_0004.
- RST=0 asserted while in REQ with ACK pending -> next cycle IMEM_REQ=0, OUT_VALID=0. After release, fetch restarts at RESET_PC.
